// File: rtl/kernel_top_vect_pipe.sv
// Lane-parallel binary-op kernel stage with a fixed-latency datapath and a
// credit-controlled output FIFO. iready depends only on registered occupancy
// and rst, never on oready.
module kernel_top_vect_pipe #(
    parameter int unsigned STREAMW    = 32,
    parameter int unsigned NLANES     = 4,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned FIFO_DEPTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ivalid,
    output logic                        iready,
    input  logic [1:0]                  op_sel,
    input  logic [NLANES*STREAMW-1:0]   kd_vin1,
    input  logic [NLANES*STREAMW-1:0]   kd_vin2,
    output logic                        ovalid,
    input  logic                        oready,
    output logic [NLANES*STREAMW-1:0]   kd_vout,
    output logic [31:0]                 obeats
);

    localparam int unsigned VW = NLANES * STREAMW;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FifoMax = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PtrLast = PW'(FIFO_DEPTH - 1);

    function automatic logic [STREAMW-1:0] lane_op(input logic [1:0] op,
                                                   input logic [STREAMW-1:0] a,
                                                   input logic [STREAMW-1:0] b);
        logic [STREAMW-1:0] r;
        unique case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a * b;
            default: r = a;
        endcase
        return r;
    endfunction

    // Pointers wrap at FIFO_DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    logic                accept;
    logic                pop;
    logic                fifo_push;
    logic [VW-1:0]       lane_res;
    logic [PIPE_DEPTH-1:0] vld_q;
    logic [VW-1:0]       dat_q [PIPE_DEPTH];
    logic [VW-1:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]       occ_q, occ_d;
    logic [31:0]         obeats_q, obeats_d;

    // occ counts in-flight plus stored beats, so a full credit pool means the
    // FIFO can always absorb everything already in the pipeline.
    assign iready    = (occ_q < FifoMax) & ~rst;
    assign accept    = ivalid & iready;
    assign ovalid    = (fifo_cnt_q != '0) & ~rst;
    assign pop       = ovalid & oready;
    assign fifo_push = vld_q[PIPE_DEPTH-1];
    assign kd_vout   = mem_q[rd_ptr_q];
    assign obeats    = obeats_q;

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        assign lane_res[g*STREAMW +: STREAMW] =
            lane_op(op_sel, kd_vin1[g*STREAMW +: STREAMW], kd_vin2[g*STREAMW +: STREAMW]);
    end

    // Valid bits shift every cycle; the datapath never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    // Data stages carry no reset; contents are qualified by vld_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            dat_q[0] <= lane_res;
        end
        for (int s = 1; s < PIPE_DEPTH; s++) begin
            dat_q[s] <= dat_q[s-1];
        end
    end

    // FIFO storage write from the last pipeline stage.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= dat_q[PIPE_DEPTH-1];
        end
    end

    // Next-state for pointers, fill level, credits and beat counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        occ_d      = occ_q;
        obeats_d   = obeats_q;
        if (accept && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!accept && pop) begin
            occ_d = occ_q - 1'b1;
        end
        if (fifo_push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!fifo_push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
        if (fifo_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            obeats_d = obeats_q + 32'd1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            occ_q      <= '0;
            obeats_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            occ_q      <= occ_d;
            obeats_q   <= obeats_d;
        end
    end

endmodule
